// File: rtl/phy_tx_pkg.sv
// phy_tx_pkg: symbol constants, SKP set length and sequencer state encoding
// shared by the phy_tx_seq sources.
package phy_tx_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;  // COM
   localparam logic [7:0] K28_1 = 8'h3C;  // SKP symbol
   localparam logic [7:0] D0_0  = 8'h00;  // logical idle / filler

   localparam int SKP_LEN = 2;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_INIT,
      ST_IDLE,
      ST_PKT,
      ST_SKP
   } state_t;

endpackage

// File: rtl/phy_tx_seq_if.sv
// phy_tx_seq_if: upstream symbol handshake plus the phy_tx_top drive bundle.
// Build option PHY_TX_SEQ_STATS_EN adds skp_count / skp_defer_max.
//
// Handshake: an upstream symbol transfers on a rising clk edge where
// up_valid and up_ready are both 1. up_ready depends only on sequencer state
// and never waits for up_valid; up_last is meaningful only with up_valid.
interface phy_tx_seq_if
`ifdef PHY_TX_SEQ_STATS_EN
   #(parameter int CNT_W = 10)
`endif
   ;
   import phy_tx_pkg::*;

   logic       tx_en;
   logic [7:0] up_data;
   logic       up_is_k;
   logic       up_valid;
   logic       up_last;
   logic       up_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_is_k;
   logic       tx_com;
   logic       skp_active;
   state_t     dbg_state;

`ifdef PHY_TX_SEQ_STATS_EN
   logic [15:0]      skp_count;
   logic [CNT_W-1:0] skp_defer_max;

   modport master (
      output tx_en, up_data, up_is_k, up_valid, up_last,
      input  up_ready, tx_data, tx_valid, tx_is_k, tx_com, skp_active,
      input  dbg_state, skp_count, skp_defer_max
   );
   modport slave (
      input  tx_en, up_data, up_is_k, up_valid, up_last,
      output up_ready, tx_data, tx_valid, tx_is_k, tx_com, skp_active,
      output dbg_state, skp_count, skp_defer_max
   );
`else
   modport master (
      output tx_en, up_data, up_is_k, up_valid, up_last,
      input  up_ready, tx_data, tx_valid, tx_is_k, tx_com, skp_active,
      input  dbg_state
   );
   modport slave (
      input  tx_en, up_data, up_is_k, up_valid, up_last,
      output up_ready, tx_data, tx_valid, tx_is_k, tx_com, skp_active,
      output dbg_state
   );
`endif

endinterface

// File: rtl/phy_tx_skp_timer.sv
// phy_tx_skp_timer: symbol interval counter and the single-entry SKP request
// flag. The counter wraps instead of reaching SKP_INTERVAL-1, so one request
// is raised per SKP_INTERVAL emitted non-SKP symbols.
module phy_tx_skp_timer #(
   parameter int SKP_INTERVAL = 354,
   parameter int CNT_W        = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic clear,
   input  logic take,
   output logic pending
);

   localparam logic [CNT_W-1:0] WRAP_AT = CNT_W'(SKP_INTERVAL - 2);

   logic [CNT_W-1:0] cnt;

   // Count emitted symbols; raise (never stack) a request on wrap. A wrap that
   // lands on the take cycle is absorbed by the SKP set being taken.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt     <= '0;
         pending <= 1'b0;
      end else begin
         if (tick) begin
            if (cnt == WRAP_AT) begin
               cnt     <= '0;
               pending <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if (take) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/phy_tx_seq.sv
// phy_tx_seq: symbol sequencer placed ahead of phy_tx_top. Emits a COM burst
// after enable, then upstream symbols or logical idle, with SKP sets inserted
// at packet boundaries. tx_* drive phy_tx_top data_in/data_valid/is_control/com.
// Build option PHY_TX_SEQ_STATS_EN adds SKP statistics outputs.
module phy_tx_seq
   import phy_tx_pkg::*;
#(
   parameter int SKP_INTERVAL = 354,
   parameter int INIT_COM_CNT = 4,
   parameter int CNT_W        = 10
) (
   input logic         clk,
   input logic         rst,
   phy_tx_seq_if.slave bus
);

   state_t     state;
   logic [3:0] init_cnt;
   logic [1:0] skp_idx;
   logic       pending;
   logic       tick;
   logic       clear;
   logic       take;

   // Every INIT/IDLE/PKT cycle puts one counted symbol on the line; the
   // counter sits at zero while off and while a SKP set is on the line.
   assign tick  = (state == ST_INIT) || (state == ST_IDLE) || (state == ST_PKT);
   assign clear = !bus.tx_en || (state == ST_OFF) || (state == ST_SKP);
   assign take  = (state == ST_IDLE) && pending && bus.tx_en;

   assign bus.up_ready  = (state == ST_PKT) || ((state == ST_IDLE) && !pending);
   assign bus.dbg_state = state;

   phy_tx_skp_timer #(
      .SKP_INTERVAL (SKP_INTERVAL),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .clear   (clear),
      .take    (take),
      .pending (pending)
   );

   // Sequencer FSM; tx_* are registered alongside the state that shows them.
   always_ff @(posedge clk) begin
      if (rst || !bus.tx_en) begin
         state          <= ST_OFF;
         init_cnt       <= '0;
         skp_idx        <= '0;
         bus.tx_data    <= D0_0;
         bus.tx_valid   <= 1'b0;
         bus.tx_is_k    <= 1'b0;
         bus.tx_com     <= 1'b0;
         bus.skp_active <= 1'b0;
      end else begin
         bus.tx_data    <= D0_0;
         bus.tx_valid   <= 1'b1;
         bus.tx_is_k    <= 1'b0;
         bus.tx_com     <= 1'b1;
         bus.skp_active <= 1'b0;
         case (state)
            ST_OFF: begin
               state       <= ST_INIT;
               init_cnt    <= '0;
               bus.tx_data <= K28_5;
               bus.tx_is_k <= 1'b1;
            end
            ST_INIT: begin
               if (init_cnt == 4'(INIT_COM_CNT - 1)) begin
                  state <= ST_IDLE;
               end else begin
                  init_cnt    <= init_cnt + 4'd1;
                  bus.tx_data <= K28_5;
                  bus.tx_is_k <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (pending) begin
                  state          <= ST_SKP;
                  skp_idx        <= '0;
                  bus.tx_data    <= K28_1;
                  bus.tx_is_k    <= 1'b1;
                  bus.tx_com     <= 1'b0;
                  bus.skp_active <= 1'b1;
               end else if (bus.up_valid) begin
                  bus.tx_data <= bus.up_data;
                  bus.tx_is_k <= bus.up_is_k;
                  if (!bus.up_last) state <= ST_PKT;
               end
            end
            ST_PKT: begin
               if (bus.up_valid) begin
                  bus.tx_data <= bus.up_data;
                  bus.tx_is_k <= bus.up_is_k;
                  if (bus.up_last) state <= ST_IDLE;
               end
            end
            ST_SKP: begin
               if (skp_idx == 2'(SKP_LEN - 1)) begin
                  state <= ST_IDLE;
               end else begin
                  skp_idx        <= skp_idx + 2'd1;
                  bus.tx_data    <= K28_1;
                  bus.tx_is_k    <= 1'b1;
                  bus.tx_com     <= 1'b0;
                  bus.skp_active <= 1'b1;
               end
            end
            default: state <= ST_OFF;
         endcase
      end
   end

`ifdef PHY_TX_SEQ_STATS_EN
   logic [CNT_W-1:0] defer_run;
   logic [CNT_W-1:0] defer_len;

   // Wait length including the current cycle, saturating at all-ones.
   assign defer_len = (defer_run == '1) ? defer_run : defer_run + 1'b1;

   // Count SKP entries and keep the longest request-to-entry wait.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.skp_count     <= '0;
         bus.skp_defer_max <= '0;
         defer_run         <= '0;
      end else if (take) begin
         if (bus.skp_count != 16'hFFFF) bus.skp_count <= bus.skp_count + 16'd1;
         if (defer_len > bus.skp_defer_max) bus.skp_defer_max <= defer_len;
         defer_run <= '0;
      end else if (pending) begin
         defer_run <= defer_len;
      end else begin
         defer_run <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_phy_tx_seq.sv
// tb_phy_tx_seq: directed bench for phy_tx_seq with SKP_INTERVAL=16 and
// INIT_COM_CNT=4. Symbol words are {valid, is_k, com, skp_active, data}.
// Cycle k counts tx cycles after the enabling edge (k=1 is the first COM).
module tb_phy_tx_seq;
   import phy_tx_pkg::*;

   localparam logic [11:0] S_OFF  = 12'h000;
   localparam logic [11:0] S_COM  = {4'b1110, 8'hBC};
   localparam logic [11:0] S_IDLE = {4'b1010, 8'h00};
   localparam logic [11:0] S_SKP  = {4'b1101, 8'h3C};

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   phy_tx_seq_if bus ();

   phy_tx_seq #(
      .SKP_INTERVAL (16),
      .INIT_COM_CNT (4),
      .CNT_W        (10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [11:0] obs();
      return {bus.tx_valid, bus.tx_is_k, bus.tx_com, bus.skp_active, bus.tx_data};
   endfunction

   function automatic logic [11:0] s_dat(input logic [7:0] d, input logic k);
      return {1'b1, k, 1'b1, 1'b0, d};
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.up_valid = 1'b0;
      bus.up_last  = 1'b0;
      bus.up_data  = 8'h00;
      bus.up_is_k  = 1'b0;
   endtask

   // Leaves the bench at k=1 (first COM on the line).
   task automatic restart();
      rst        = 1'b1;
      bus.tx_en  = 1'b0;
      idle_inputs();
      step();
      rst       = 1'b0;
      bus.tx_en = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.tx_en = 1'b1;
      bus.up_valid = 1'b1;
      bus.up_data  = 8'h77;
      bus.up_last  = 1'b0;
      bus.up_is_k  = 1'b0;
      repeat (3) step();
      n_checks++;
      if (obs() !== S_OFF) $display("FAIL reset_tx: got %h required %h", obs(), S_OFF);
      else n_pass++;
      n_checks++;
      if (bus.up_ready !== 1'b0) $display("FAIL reset_ready: got %b required 0", bus.up_ready);
      else n_pass++;
      n_checks++;
      if (bus.dbg_state !== ST_OFF) $display("FAIL reset_state: got %0d required %0d", bus.dbg_state, ST_OFF);
      else n_pass++;
      rst       = 1'b0;
      bus.tx_en = 1'b0;
      idle_inputs();
      step();
      n_checks++;
      if (obs() !== S_OFF) $display("FAIL off_hold: got %h required %h", obs(), S_OFF);
      else n_pass++;
   endtask

   task automatic test_startup_skp();
      logic [11:0] e;
      logic        er;
      restart();
      for (int k = 1; k <= 38; k++) begin
         if (k > 1) step();
         if (k <= 4) e = S_COM;
         else if (k == 17 || k == 18 || k == 35 || k == 36) e = S_SKP;
         else e = S_IDLE;
         er = !(k <= 4 || k == 16 || k == 17 || k == 18 || k == 34 || k == 35 || k == 36);
         n_checks++;
         if (obs() !== e) $display("FAIL startup_sym k=%0d: got %h required %h", k, obs(), e);
         else n_pass++;
         n_checks++;
         if (bus.up_ready !== er) $display("FAIL startup_ready k=%0d: got %b required %b", k, bus.up_ready, er);
         else n_pass++;
      end
   endtask

   task automatic test_passthrough();
      logic [7:0] d;
      restart();
      repeat (4) step();
      for (int i = 0; i < 5; i++) begin
         d = 8'(17 * (i + 1));
         bus.up_valid = 1'b1;
         bus.up_data  = d;
         bus.up_last  = (i == 4);
         n_checks++;
         if (bus.up_ready !== 1'b1) $display("FAIL pass_ready i=%0d: got %b required 1", i, bus.up_ready);
         else n_pass++;
         step();
         n_checks++;
         if (obs() !== s_dat(d, 1'b0)) $display("FAIL pass_data i=%0d: got %h required %h", i, obs(), s_dat(d, 1'b0));
         else n_pass++;
      end
      idle_inputs();
      step();
      n_checks++;
      if (obs() !== S_IDLE) $display("FAIL pass_after: got %h required %h", obs(), S_IDLE);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] dv [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hFB};
      logic       lv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic       kv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      restart();
      repeat (4) step();
      for (int i = 0; i < 4; i++) begin
         bus.up_valid = 1'b1;
         bus.up_data  = dv[i];
         bus.up_last  = lv[i];
         bus.up_is_k  = kv[i];
         n_checks++;
         if (bus.up_ready !== 1'b1) $display("FAIL b2b_ready i=%0d: got %b required 1", i, bus.up_ready);
         else n_pass++;
         step();
         n_checks++;
         if (obs() !== s_dat(dv[i], kv[i])) $display("FAIL b2b_data i=%0d: got %h required %h", i, obs(), s_dat(dv[i], kv[i]));
         else n_pass++;
      end
      idle_inputs();
   endtask

   // Counter wraps at k=15 inside the packet; SKP follows the last byte.
   task automatic test_deferral();
      logic [11:0] e;
      logic [7:0]  nb;
      logic        sent;
      restart();
      repeat (4) step();
      nb = 8'hA0;
      for (int k = 5; k <= 16; k++) begin
         sent = (k <= 9) || (k >= 12);
         bus.up_valid = sent;
         bus.up_data  = sent ? nb : 8'h00;
         bus.up_last  = (k == 16);
         n_checks++;
         if (bus.up_ready !== 1'b1) $display("FAIL defer_ready k=%0d: got %b required 1", k, bus.up_ready);
         else n_pass++;
         step();
         e = sent ? s_dat(nb, 1'b0) : S_IDLE;
         n_checks++;
         if (obs() !== e) $display("FAIL defer_sym k=%0d: got %h required %h", k + 1, obs(), e);
         else n_pass++;
         if (sent) nb = nb + 8'd1;
      end
      idle_inputs();
      n_checks++;
      if (bus.up_ready !== 1'b0) $display("FAIL defer_ready_take: got %b required 0", bus.up_ready);
      else n_pass++;
      for (int k = 18; k <= 20; k++) begin
         step();
         e = (k == 20) ? S_IDLE : S_SKP;
         n_checks++;
         if (obs() !== e) $display("FAIL defer_skp k=%0d: got %h required %h", k, obs(), e);
         else n_pass++;
         n_checks++;
         if (bus.up_ready !== (k == 20)) $display("FAIL defer_skp_ready k=%0d: got %b required %b", k, bus.up_ready, (k == 20));
         else n_pass++;
      end
   endtask

   task automatic test_disable_mid_skp();
      logic [11:0] e;
      restart();
      repeat (16) step();
      n_checks++;
      if (obs() !== S_SKP) $display("FAIL dis_first_skp: got %h required %h", obs(), S_SKP);
      else n_pass++;
      bus.tx_en = 1'b0;
      step();
      n_checks++;
      if (obs() !== S_OFF) $display("FAIL dis_off: got %h required %h", obs(), S_OFF);
      else n_pass++;
      n_checks++;
      if (bus.up_ready !== 1'b0) $display("FAIL dis_ready: got %b required 0", bus.up_ready);
      else n_pass++;
      step();
      bus.tx_en = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         step();
         if (k <= 4) e = S_COM;
         else if (k >= 17) e = S_SKP;
         else e = S_IDLE;
         n_checks++;
         if (obs() !== e) $display("FAIL reen_sym k=%0d: got %h required %h", k, obs(), e);
         else n_pass++;
      end
   endtask

   task automatic test_rst_mid_packet();
      restart();
      repeat (4) step();
      bus.up_valid = 1'b1;
      bus.up_data  = 8'h5A;
      bus.up_last  = 1'b0;
      step();
      bus.up_data = 8'h5B;
      rst = 1'b1;
      step();
      n_checks++;
      if (obs() !== S_OFF) $display("FAIL rst_pkt_tx: got %h required %h", obs(), S_OFF);
      else n_pass++;
      n_checks++;
      if (bus.up_ready !== 1'b0) $display("FAIL rst_pkt_ready: got %b required 0", bus.up_ready);
      else n_pass++;
      rst = 1'b0;
      idle_inputs();
      step();
      n_checks++;
      if (obs() !== S_COM) $display("FAIL rst_pkt_restart: got %h required %h", obs(), S_COM);
      else n_pass++;
   endtask

`ifdef PHY_TX_SEQ_STATS_EN
   task automatic test_stats();
      restart();
      repeat (53) step();
      n_checks++;
      if (bus.skp_count !== 16'd3) $display("FAIL stats_count: got %0d required 3", bus.skp_count);
      else n_pass++;
      n_checks++;
      if (bus.skp_defer_max !== 10'd1) $display("FAIL stats_defer_idle: got %0d required 1", bus.skp_defer_max);
      else n_pass++;
      restart();
      repeat (4) step();
      for (int k = 5; k <= 21; k++) begin
         bus.up_valid = 1'b1;
         bus.up_data  = 8'(k);
         bus.up_last  = (k == 21);
         step();
      end
      idle_inputs();
      repeat (3) step();
      n_checks++;
      if (bus.skp_defer_max !== 10'd7) $display("FAIL stats_defer: got %0d required 7", bus.skp_defer_max);
      else n_pass++;
      n_checks++;
      if (bus.skp_count !== 16'd1) $display("FAIL stats_count_rst: got %0d required 1", bus.skp_count);
      else n_pass++;
   endtask
`endif

   // test sequence and final report
   initial begin
      rst       = 1'b1;
      bus.tx_en = 1'b0;
      idle_inputs();
      test_reset();
      test_startup_skp();
      test_passthrough();
      test_back_to_back();
      test_deferral();
      test_disable_mid_skp();
      test_rst_mid_packet();
`ifdef PHY_TX_SEQ_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
